cordic_scheduler: RTL and testbench

Shares one iterative CORDIC rotation core among `NUM_REQ` requesters. Each request carries an angle and a direction sign. The block picks one request at a time with round-robin priority, loads the core by pulsing its synchronous reset, and counts the core's iterations. It then captures the cosine/sine result and returns it on a valid/ready response port tagged with the requester ID. It sits between the angle-producing clients and the single `cordic` instance, and it owns that instance's `reset`, `theta` and `Sign` pins.

---
 rtl/cordic_scheduler.sv | 155 +++++++++++++++
 tb/tb_cordic_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_scheduler.sv
// cordic_scheduler: round-robin arbiter that time-shares one iterative CORDIC core.
// Ports:
//   clock, reset          - clock and synchronous active-high reset
//   req_valid/ready       - per-requester handshake, ready is one-hot and only in IDLE
//   req_theta, req_sign   - packed per-requester angle and rotation sign
//   rsp_valid/ready       - result handshake; rsp_id/rsp_cos/rsp_sin held stable while valid
//   busy                  - high whenever an operation or response is outstanding
//   core_reset/theta/sign - drive the shared core's reset, theta and Sign pins
//   core_cos, core_sin    - the core's CosX/SinX outputs
module cordic_scheduler #(
    parameter int REG_SIZE = 15,
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 2,
    parameter int ITER     = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*(REG_SIZE+1)-1:0] req_theta,
    input  logic [NUM_REQ-1:0]           req_sign,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_W-1:0]              rsp_id,
    output logic [REG_SIZE+1:0]          rsp_cos,
    output logic [REG_SIZE+1:0]          rsp_sin,
    output logic                         busy,
    output logic                         core_reset,
    output logic [REG_SIZE:0]            core_theta,
    output logic                         core_sign,
    input  logic [REG_SIZE+1:0]          core_cos,
    input  logic [REG_SIZE+1:0]          core_sin
);
    localparam int W  = REG_SIZE + 1;
    localparam int RW = REG_SIZE + 2;
    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d, id_q, id_d, rsp_id_q, rsp_id_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    theta_q, theta_d;
    logic            sign_q, sign_d, rsp_valid_q, rsp_valid_d;
    logic [RW-1:0]   rsp_cos_q, rsp_cos_d, rsp_sin_q, rsp_sin_d;

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] gnt;
    logic            found;
    logic [W-1:0]    sel_theta;
    logic            sel_sign;

    // Search ptr+1, ptr+2, ... wrapping modulo NUM_REQ; the first valid index wins.
    always_comb begin
        found = 1'b0;
        gnt = '0;
        sum = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
            if (!found && req_valid[sum[ID_W-1:0]]) begin
                found = 1'b1;
                gnt = sum[ID_W-1:0];
            end
        end
        sel_theta = '0;
        sel_sign = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (gnt == ID_W'(j)) begin
                sel_theta = req_theta[j*W +: W];
                sel_sign = req_sign[j];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        id_d = id_q;
        theta_d = theta_q;
        sign_d = sign_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d = rsp_id_q;
        rsp_cos_d = rsp_cos_q;
        rsp_sin_d = rsp_sin_q;
        case (state_q)
            IDLE: if (found) begin
                state_d = LOAD;
                ptr_d = gnt;
                id_d = gnt;
                theta_d = sel_theta;
                sign_d = sel_sign;
            end
            LOAD: begin
                cnt_d = '0;
                state_d = RUN;
            end
            // The core's outputs already include the iteration of the current cycle,
            // so at cnt == ITER-1 they hold the full ITER-iteration result.
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(ITER-1)) begin
                    rsp_cos_d = core_cos;
                    rsp_sin_d = core_sin;
                    rsp_id_d = id_q;
                    rsp_valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q <= ID_W'(NUM_REQ-1);
            cnt_q <= '0;
            id_q <= '0;
            theta_q <= '0;
            sign_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q <= '0;
            rsp_cos_q <= '0;
            rsp_sin_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            id_q <= id_d;
            theta_q <= theta_d;
            sign_q <= sign_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q <= rsp_id_d;
            rsp_cos_q <= rsp_cos_d;
            rsp_sin_q <= rsp_sin_d;
        end
    end

    assign req_ready  = (state_q == IDLE && found && !reset) ? NUM_REQ'(1) << gnt : '0;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_cos    = rsp_cos_q;
    assign rsp_sin    = rsp_sin_q;
    assign busy       = state_q != IDLE;
    // Core is held in reset everywhere except RUN so it never free-runs.
    assign core_reset = state_q != RUN;
    assign core_theta = theta_q;
    assign core_sign  = sign_q;
endmodule

// File: tb/tb_cordic_scheduler.sv
// tb_cordic_scheduler: directed bench for cordic_scheduler with a behavioural CORDIC core.
module tb_cordic_scheduler;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [63:0] req_theta = '0;
    logic [3:0]  req_sign = '0;
    logic        rsp_ready = 1'b0;
    logic [3:0]  req_ready;
    logic        rsp_valid, busy, core_reset, core_sign;
    logic [1:0]  rsp_id;
    logic [16:0] rsp_cos, rsp_sin, core_cos, core_sin;
    logic [15:0] core_theta;

    int total = 0;
    int bad = 0;

    cordic_scheduler dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_theta(req_theta),
        .req_sign(req_sign), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_cos(rsp_cos), .rsp_sin(rsp_sin),
        .busy(busy), .core_reset(core_reset), .core_theta(core_theta),
        .core_sign(core_sign), .core_cos(core_cos), .core_sin(core_sin)
    );

    always #5 clock = ~clock;

    localparam logic signed [16:0] X0 = 17'sd19898;
    localparam logic [15:0] ATAN [16] = '{16'd8192, 16'd4836, 16'd2555, 16'd1297,
                                          16'd651, 16'd326, 16'd163, 16'd81,
                                          16'd41, 16'd20, 16'd10, 16'd5,
                                          16'd3, 16'd1, 16'd1, 16'd0};

    function automatic logic [49:0] step(input logic signed [16:0] x, input logic signed [16:0] y,
                                         input logic [15:0] z, input logic [3:0] i, input logic s);
        logic signed [16:0] xs, ys;
        xs = x >>> i;
        ys = y >>> i;
        if (z[15] ^ s) return {x + ys, y - xs, z + ATAN[i]};
        return {x - ys, y + xs, z - ATAN[i]};
    endfunction

    function automatic logic [33:0] run_model(input logic [15:0] th, input logic s);
        logic [49:0] v;
        v = {X0, 17'd0, th};
        for (int i = 0; i < 16; i++) v = step(v[49:33], v[32:16], v[15:0], 4'(i), s);
        return v[49:16];
    endfunction

    // Core model: registered state, outputs show the current cycle's iteration combinationally.
    logic signed [16:0] cx_q, cy_q;
    logic [15:0]        cz_q;
    logic [3:0]         ci_q;
    logic               cs_q;
    logic [49:0]        nxt;
    always_comb nxt = step(cx_q, cy_q, cz_q, ci_q, cs_q);
    assign core_cos = nxt[49:33];
    assign core_sin = nxt[32:16];
    always @(posedge clock) begin
        if (core_reset) begin
            cx_q <= X0;
            cy_q <= '0;
            cz_q <= core_theta;
            ci_q <= '0;
            cs_q <= core_sign;
        end else begin
            cx_q <= nxt[49:33];
            cy_q <= nxt[32:16];
            cz_q <= nxt[15:0];
            ci_q <= ci_q + 4'd1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    logic [3:0] ge [7] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd8};
    logic [3:0] gv [7];
    int         gt [7];

    initial begin
        logic [33:0] e;
        logic [35:0] held;
        logic [16:0] rc, rs;
        logic [1:0]  ri;
        int n, k, lows, nr, tr, seen1;
        // reset values, with all requests asserted during reset
        req_valid = 4'hF;
        cyc(); #1;
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_cos", rsp_cos, 0);
        chk("rst_rsp_sin", rsp_sin, 0);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_core_theta", core_theta, 0);
        chk("rst_core_sign", core_sign, 0);
        chk("rst_req_ready", req_ready, 0);
        req_valid = '0;
        cyc();
        reset = 1'b0;
        // single request from requester 2
        req_theta[47:32] = 16'h1000;
        req_valid = 4'b0100;
        #1;
        chk("single_grant", req_ready, 4'b0100);
        cyc();
        req_valid = '0;
        #1;
        chk("load_ready", req_ready, 0);
        chk("load_core_reset", core_reset, 1);
        chk("load_theta", core_theta, 16'h1000);
        chk("load_busy", busy, 1);
        lows = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(); #1;
            if (!core_reset && !rsp_valid) lows++;
        end
        chk("run_cycles", lows, 16);
        cyc(); #1;
        e = run_model(16'h1000, 1'b0);
        chk("single_valid", rsp_valid, 1);
        chk("single_id", rsp_id, 2);
        chk("single_cos", rsp_cos, e[33:17]);
        chk("single_sin", rsp_sin, e[16:0]);
        chk("hold_core_reset", core_reset, 1);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        #1;
        chk("single_drop", rsp_valid, 0);
        chk("single_idle", busy, 0);
        // round robin from reset, then only requesters 1 and 3
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        req_theta = {16'h3800, 16'h2800, 16'h1800, 16'h0800};
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 200 && n < 7; c++) begin
            #1;
            if (req_ready != 0) begin
                gv[n] = req_ready;
                gt[n] = c;
                n++;
            end
            cyc();
            if (n == 5) req_valid = 4'b1010;
        end
        chk("rr_count", n, 7);
        for (int i = 0; i < n; i++) chk($sformatf("rr_grant%0d", i), gv[i], ge[i]);
        for (int i = 1; i < n; i++) chk($sformatf("rr_gap%0d", i), gt[i] - gt[i-1], 19);
        // backpressure on requester 3's response with requester 0 pending
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        k = 0;
        #1;
        while (!rsp_valid && k < 40) begin
            cyc(); #1;
            k++;
        end
        chk("bp_valid", rsp_valid, 1);
        chk("bp_latency", k, 17);
        e = run_model(16'h3800, 1'b0);
        chk("bp_id", rsp_id, 3);
        chk("bp_cos", rsp_cos, e[33:17]);
        chk("bp_sin", rsp_sin, e[16:0]);
        held = {rsp_id, rsp_cos, rsp_sin};
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_stable", {rsp_id, rsp_cos, rsp_sin}, held);
            chk("bp_busy", busy, 1);
            chk("bp_ready", req_ready, 0);
            chk("bp_core_reset", core_reset, 1);
        end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        #1;
        chk("bp_release", rsp_valid, 0);
        chk("bp_next_grant", req_ready, 4'b0001);
        // reset while requester 0's operation is at cnt 7
        for (int i = 0; i < 9; i++) cyc();
        #1;
        chk("mid_running", core_reset, 0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_core_reset", core_reset, 1);
        chk("mid_regrant", req_ready, 4'b0001);
        cyc();
        req_valid = '0;
        rsp_ready = 1'b1;
        nr = 0;
        tr = 0;
        rc = '0;
        rs = '0;
        ri = '0;
        for (int j = 1; j <= 25; j++) begin
            #1;
            if (rsp_valid) begin
                nr++;
                tr = j;
                rc = rsp_cos;
                rs = rsp_sin;
                ri = rsp_id;
            end
            cyc();
        end
        e = run_model(16'h0800, 1'b0);
        chk("mid_rsp_count", nr, 1);
        chk("mid_rsp_time", tr, 18);
        chk("mid_rsp_id", ri, 0);
        chk("mid_rsp_cos", rc, e[33:17]);
        chk("mid_rsp_sin", rs, e[16:0]);
        // requester 3 with sign 1; requester 1 withdraws before being served
        rsp_ready = 1'b0;
        req_theta[63:48] = 16'h2345;
        req_sign = 4'b1000;
        req_valid = 4'b1000;
        #1;
        chk("sign_grant", req_ready, 4'b1000);
        cyc();
        req_valid = '0;
        #1;
        chk("sign_load", core_sign, 1);
        chk("sign_load_reset", core_reset, 1);
        for (int i = 0; i < 3; i++) cyc();
        req_valid = 4'b0010;
        seen1 = 0;
        k = 0;
        #1;
        while (!rsp_valid && k < 40) begin
            if (req_ready[1]) seen1++;
            cyc();
            if (k == 5) req_valid = '0;
            #1;
            k++;
        end
        e = run_model(16'h2345, 1'b1);
        chk("sign_valid", rsp_valid, 1);
        chk("sign_id", rsp_id, 3);
        chk("sign_cos", rsp_cos, e[33:17]);
        chk("sign_sin", rsp_sin, e[16:0]);
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            if (req_ready[1] || busy) seen1++;
        end
        chk("withdrawn_never_granted", seen1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
